// File: rtl/hyperbus_responder.sv
// HyperRAM-style device end of a HyperBus link, one clk_i cycle per CK period.
// Decodes CA, applies the CR0-selected initial latency, and serves memory and register bursts.
module hyperbus_responder #(
  parameter int          MEM_WORDS  = 4096,
  parameter int          WRAP_WORDS = 16,
  parameter logic [15:0] CR0_RESET  = 16'h8F1F,
  parameter logic [15:0] ID0_VALUE  = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hyper_cs_ni,
  input  logic [15:0] hyper_dq_i,
  input  logic [1:0]  hyper_rwds_i,
  output logic [15:0] hyper_dq_o,
  output logic        hyper_dq_oe_o,
  output logic [1:0]  hyper_rwds_o,
  output logic        hyper_rwds_oe_o
);

  // state | meaning
  // IDLE  | waiting for cs_n low; first CA word captured on entry to CA
  // CA    | capturing CA words 1 and 2
  // LAT   | initial latency down-count
  // WDATA | memory write burst
  // RDATA | memory or register read burst
  // REGW  | single zero-latency register write word
  // DONE  | transaction finished, waiting for cs_n high
  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGW, DONE} state_t;

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] WRAP_MASK = AW'(WRAP_WORDS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);

  state_t        state;
  logic [15:0]   mem [MEM_WORDS];
  logic [15:0]   cr0;
  logic          is_read;
  logic          is_reg;
  logic          is_linear;
  logic [12:0]   ca_hi;
  logic [15:0]   ca_mid;
  logic [31:0]   reg_addr;
  logic [AW-1:0] addr;
  logic [3:0]    cnt;

  logic [31:0]   ca_addr;
  logic [3:0]    tacc;
  logic [3:0]    lat;
  logic [15:0]   reg_word;
  logic [15:0]   rd_word;
  logic [AW-1:0] addr_next;

  assign ca_addr = {ca_hi, ca_mid, hyper_dq_i[2:0]};

  always_comb begin
    case (cr0[7:4])
      4'h0:    tacc = 4'd5;
      4'h1:    tacc = 4'd6;
      4'hE:    tacc = 4'd3;
      4'hF:    tacc = 4'd4;
      default: tacc = 4'd6;
    endcase
    lat = cr0[3] ? {tacc[2:0], 1'b0} : tacc;
  end

  always_comb begin
    case (reg_addr)
      32'h0000_0000: reg_word = ID0_VALUE;
      32'h0000_0001: reg_word = 16'h0001;
      32'h0000_0800: reg_word = cr0;
      32'h0000_0801: reg_word = 16'hFFC1;
      default:       reg_word = 16'h0000;
    endcase
    rd_word = is_reg ? reg_word : mem[addr];
  end

  // Wrapped bursts keep the group-aligned upper bits and roll the low bits.
  always_comb begin
    if (is_linear)
      addr_next = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    else
      addr_next = (addr & ~WRAP_MASK) | ((addr + 1'b1) & WRAP_MASK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !hyper_cs_ni && state == WDATA) begin
      if (!hyper_rwds_i[1]) mem[addr][15:8] <= hyper_dq_i[15:8];
      if (!hyper_rwds_i[0]) mem[addr][7:0]  <= hyper_dq_i[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      cr0             <= CR0_RESET;
      is_read         <= 1'b0;
      is_reg          <= 1'b0;
      is_linear       <= 1'b0;
      ca_hi           <= '0;
      ca_mid          <= '0;
      reg_addr        <= '0;
      addr            <= '0;
      cnt             <= '0;
      hyper_dq_o      <= '0;
      hyper_dq_oe_o   <= 1'b0;
      hyper_rwds_o    <= '0;
      hyper_rwds_oe_o <= 1'b0;
    end else if (hyper_cs_ni) begin
      state           <= IDLE;
      hyper_dq_o      <= '0;
      hyper_dq_oe_o   <= 1'b0;
      hyper_rwds_o    <= '0;
      hyper_rwds_oe_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          is_read         <= hyper_dq_i[15];
          is_reg          <= hyper_dq_i[14];
          is_linear       <= hyper_dq_i[13];
          ca_hi           <= hyper_dq_i[12:0];
          cnt             <= 4'd0;
          hyper_rwds_o    <= {2{cr0[3]}};
          hyper_rwds_oe_o <= 1'b1;
          state           <= CA;
        end
        CA: begin
          if (cnt == 4'd0) begin
            ca_mid <= hyper_dq_i;
            cnt    <= 4'd1;
          end else begin
            reg_addr <= ca_addr;
            addr     <= ca_addr[AW-1:0];
            cnt      <= lat - 4'd1;
            // Only reads keep RWDS driven through the latency window.
            if (!is_read) begin
              hyper_rwds_o    <= '0;
              hyper_rwds_oe_o <= 1'b0;
            end
            state <= (!is_read && is_reg) ? REGW : LAT;
          end
        end
        LAT: begin
          if (cnt == 4'd0) begin
            if (is_read) begin
              hyper_dq_o      <= rd_word;
              hyper_dq_oe_o   <= 1'b1;
              hyper_rwds_o    <= 2'b10;
              hyper_rwds_oe_o <= 1'b1;
              addr            <= addr_next;
              state           <= RDATA;
            end else begin
              state <= WDATA;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RDATA: begin
          hyper_dq_o <= rd_word;
          addr       <= addr_next;
        end
        WDATA: begin
          addr <= addr_next;
        end
        REGW: begin
          if (reg_addr == 32'h0000_0800) cr0 <= hyper_dq_i;
          state <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
